// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter. It chooses one of SLAVE_X_MASTER_NUM requesting masters,
// holds the grant across wait states, and pipelines the owner into the data phase.
module ahb_slave_arbiter #(
    parameter int SLAVE_X_MASTER_NUM = 3,
    parameter int ARB_TYPE           = 1,
    parameter int MAX_BEATS          = 16
) (
    input  logic                                  hclk,
    input  logic                                  hreset,
    input  logic [SLAVE_X_MASTER_NUM-1:0]         hreq,
    input  logic [SLAVE_X_MASTER_NUM-1:0]         hmastlock,
    input  logic                                  hready,
    output logic [SLAVE_X_MASTER_NUM-1:0]         hgrant,
    output logic [$clog2(SLAVE_X_MASTER_NUM)-1:0] hmaster,
    output logic                                  hmaster_valid,
    output logic [$clog2(SLAVE_X_MASTER_NUM)-1:0] hmaster_d,
    output logic                                  hmaster_d_valid
);
    // state | meaning
    // IDLE  | no owner, hgrant all-zero
    // GRANT | one master owns the address phase
    localparam int NM = SLAVE_X_MASTER_NUM;
    localparam int MW = $clog2(NM);
    localparam int CW = $clog2(MAX_BEATS + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_n;
    logic [NM-1:0]   grant_q, grant_n;
    logic [MW-1:0]   master_q, master_n;
    logic            valid_q, valid_n;
    logic [MW-1:0]   master_d_q, master_d_n;
    logic            d_valid_q, d_valid_n;
    logic [CW-1:0]   count_q, count_n;
    logic [MW-1:0]   last_q, last_n;

    logic            req_owner;
    logic            lock_owner;
    logic [NM-1:0]   others;
    logic            expired;
    logic            issue;
    logic [NM-1:0]   search;
    logic [MW-1:0]   win;

    // In round-robin mode the search starts just after the last owner.
    // In fixed-priority mode it always starts at index 0.
    function automatic logic [MW-1:0] pick_winner(input logic [NM-1:0] req,
                                                   input logic [MW-1:0] last);
        logic [MW-1:0] w;
        logic          found;
        int            start;
        int            idx;
        w     = '0;
        found = 1'b0;
        start = (ARB_TYPE == 1) ? (int'(last) + 1) % NM : 0;
        for (int i = 0; i < NM; i++) begin
            idx = (start + i) % NM;
            if (!found && req[idx]) begin
                w     = MW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign req_owner  = |(hreq & grant_q);
    assign lock_owner = |(hmastlock & grant_q);
    assign others     = hreq & ~grant_q;
    assign expired    = (count_q == CW'(MAX_BEATS));
    assign win        = pick_winner(search, last_q);

    always_comb begin
        state_n    = state_q;
        grant_n    = grant_q;
        master_n   = master_q;
        valid_n    = valid_q;
        count_n    = count_q;
        last_n     = last_q;
        issue      = 1'b0;
        search     = hreq;
        master_d_n = master_d_q;
        d_valid_n  = d_valid_q;

        if (hready) begin
            master_d_n = master_q;
            d_valid_n  = valid_q;
        end

        case (state_q)
            IDLE: begin
                if (|hreq) begin
                    issue = 1'b1;
                end
            end
            GRANT: begin
                if (hready) begin
                    if (!req_owner || (expired && !lock_owner && (|others))) begin
                        // The owner never competes in its own re-arbitration.
                        search = others;
                        if (|others) begin
                            issue = 1'b1;
                        end else begin
                            state_n = IDLE;
                            grant_n = '0;
                            valid_n = 1'b0;
                            count_n = '0;
                        end
                    end else if (!expired) begin
                        count_n = count_q + CW'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                valid_n = 1'b0;
            end
        endcase

        if (issue) begin
            state_n  = GRANT;
            grant_n  = NM'(1) << win;
            master_n = win;
            valid_n  = 1'b1;
            count_n  = '0;
            last_n   = win;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            master_q   <= '0;
            valid_q    <= 1'b0;
            master_d_q <= '0;
            d_valid_q  <= 1'b0;
            count_q    <= '0;
            last_q     <= MW'(NM - 1);
        end else begin
            state_q    <= state_n;
            grant_q    <= grant_n;
            master_q   <= master_n;
            valid_q    <= valid_n;
            master_d_q <= master_d_n;
            d_valid_q  <= d_valid_n;
            count_q    <= count_n;
            last_q     <= last_n;
        end
    end

    assign hgrant          = grant_q;
    assign hmaster         = master_q;
    assign hmaster_valid   = valid_q;
    assign hmaster_d       = master_d_q;
    assign hmaster_d_valid = d_valid_q;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Bench for ahb_slave_arbiter. A round-robin and a fixed-priority instance share the same stimulus.
// Each cycle a reference model pushes the expected outputs, and the bench pops them after the edge.
module tb_ahb_slave_arbiter;
    logic       hclk;
    logic       hreset;
    logic [2:0] hreq;
    logic [2:0] hmastlock;
    logic       hready;

    logic [2:0] g_rr, g_fx;
    logic [1:0] m_rr, m_fx, md_rr, md_fx;
    logic       v_rr, v_fx, mdv_rr, mdv_fx;

    int checks = 0;
    int passed = 0;

    ahb_slave_arbiter #(.SLAVE_X_MASTER_NUM(3), .ARB_TYPE(1), .MAX_BEATS(4)) u_rr (
        .hclk(hclk), .hreset(hreset), .hreq(hreq), .hmastlock(hmastlock), .hready(hready),
        .hgrant(g_rr), .hmaster(m_rr), .hmaster_valid(v_rr),
        .hmaster_d(md_rr), .hmaster_d_valid(mdv_rr));

    ahb_slave_arbiter #(.SLAVE_X_MASTER_NUM(3), .ARB_TYPE(0), .MAX_BEATS(4)) u_fx (
        .hclk(hclk), .hreset(hreset), .hreq(hreq), .hmastlock(hmastlock), .hready(hready),
        .hgrant(g_fx), .hmaster(m_fx), .hmaster_valid(v_fx),
        .hmaster_d(md_fx), .hmaster_d_valid(mdv_fx));

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic [8:0] obs_rr, obs_fx;
    assign obs_rr = {g_rr, m_rr, v_rr, md_rr, mdv_rr};
    assign obs_fx = {g_fx, m_fx, v_fx, md_fx, mdv_fx};

    typedef struct {
        logic [2:0] g;
        logic [1:0] m;
        logic       v;
        logic [1:0] md;
        logic       mdv;
        int         cnt;
        int         last;
    } mst_t;

    typedef struct {
        logic [8:0] rr;
        logic [8:0] fx;
    } exp_t;

    exp_t sb[$];
    mst_t ms_rr, ms_fx;

    function automatic mst_t mreset();
        mst_t s;
        s.g = 3'b000; s.m = 2'd0; s.v = 1'b0; s.md = 2'd0; s.mdv = 1'b0;
        s.cnt = 0; s.last = 2;
        return s;
    endfunction

    function automatic mst_t mstep(mst_t s, bit rr, logic [2:0] req, logic [2:0] lock,
                                   logic rdy, logic rst);
        mst_t       n;
        int         own;
        int         w;
        int         idx;
        logic [2:0] cand;
        bit         pick_it;
        if (rst) return mreset();
        n = s;
        pick_it = 0;
        cand = req;
        if (rdy) begin
            n.md  = s.m;
            n.mdv = s.v;
        end
        if (!s.v) begin
            if (req != 3'b000) pick_it = 1;
        end else if (rdy) begin
            own = int'(s.m);
            cand = req & ~(3'b001 << own);
            if (!req[own] || (s.cnt == 4 && !lock[own] && cand != 3'b000)) begin
                if (cand != 3'b000) pick_it = 1;
                else begin
                    n.g = 3'b000;
                    n.v = 1'b0;
                    n.cnt = 0;
                end
            end else if (s.cnt < 4) begin
                n.cnt = s.cnt + 1;
            end
        end
        if (pick_it) begin
            w = -1;
            for (int k = 0; k < 3; k++) begin
                idx = rr ? (s.last + 1 + k) % 3 : k;
                if (w < 0 && cand[idx]) w = idx;
            end
            n.g = 3'b001 << w;
            n.m = w[1:0];
            n.v = 1'b1;
            n.cnt = 0;
            n.last = w;
        end
        return n;
    endfunction

    function automatic logic [8:0] vec(mst_t s);
        return {s.g, s.m, s.v, s.md, s.mdv};
    endfunction

    task automatic cycle(input logic [2:0] req, input logic [2:0] lock,
                         input logic rdy, input logic rst);
        exp_t e;
        hreq = req; hmastlock = lock; hready = rdy; hreset = rst;
        ms_rr = mstep(ms_rr, 1'b1, req, lock, rdy, rst);
        ms_fx = mstep(ms_fx, 1'b0, req, lock, rdy, rst);
        e.rr = vec(ms_rr);
        e.fx = vec(ms_fx);
        sb.push_back(e);
        @(posedge hclk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            cycle(3'b111, 3'b000, 1'b1, 1'b1);
            e = sb.pop_front();
            checks += 2;
            if (obs_rr !== e.rr) $display("FAIL reset rr: got %b want %b", obs_rr, e.rr); else passed++;
            if (obs_fx !== e.fx) $display("FAIL reset fx: got %b want %b", obs_fx, e.fx); else passed++;
        end
        checks++;
        if (obs_rr !== 9'b0) $display("FAIL reset_zero: got %b want %b", obs_rr, 9'b0); else passed++;
    endtask

    task automatic test_first_grant();
        exp_t e;
        cycle(3'b110, 3'b000, 1'b1, 1'b0);
        e = sb.pop_front();
        checks += 3;
        if (obs_rr !== e.rr) $display("FAIL first_grant rr: got %b want %b", obs_rr, e.rr); else passed++;
        if (obs_fx !== e.fx) $display("FAIL first_grant fx: got %b want %b", obs_fx, e.fx); else passed++;
        if ({g_rr, m_rr, v_rr} !== {3'b010, 2'd1, 1'b1})
            $display("FAIL first_grant_owner: got %b/%0d/%b want 010/1/1", g_rr, m_rr, v_rr);
        else passed++;
        cycle(3'b110, 3'b000, 1'b1, 1'b0);
        e = sb.pop_front();
        checks += 3;
        if (obs_rr !== e.rr) $display("FAIL first_data rr: got %b want %b", obs_rr, e.rr); else passed++;
        if (obs_fx !== e.fx) $display("FAIL first_data fx: got %b want %b", obs_fx, e.fx); else passed++;
        if ({md_rr, mdv_rr} !== {2'd1, 1'b1})
            $display("FAIL first_data_phase: got %0d/%b want 1/1", md_rr, mdv_rr);
        else passed++;
    endtask

    task automatic test_quantum();
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            cycle(3'b111, 3'b000, 1'b1, 1'b0);
            e = sb.pop_front();
            checks += 2;
            if (obs_rr !== e.rr) $display("FAIL quantum rr cyc %0d: got %b want %b", i, obs_rr, e.rr); else passed++;
            if (obs_fx !== e.fx) $display("FAIL quantum fx cyc %0d: got %b want %b", i, obs_fx, e.fx); else passed++;
            if (i == 3) begin
                checks += 2;
                if (g_rr !== 3'b100) $display("FAIL quantum_rr_to2: got %b want 100", g_rr); else passed++;
                if (g_fx !== 3'b001) $display("FAIL quantum_fx_to0: got %b want 001", g_fx); else passed++;
            end
            if (i == 8) begin
                checks++;
                if (g_rr !== 3'b001) $display("FAIL quantum_rr_wrap: got %b want 001", g_rr); else passed++;
            end
        end
    endtask

    task automatic test_release_wait();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            cycle(3'b000, 3'b000, (i == 3), 1'b0);
            e = sb.pop_front();
            checks += 3;
            if (obs_rr !== e.rr) $display("FAIL release rr cyc %0d: got %b want %b", i, obs_rr, e.rr); else passed++;
            if (obs_fx !== e.fx) $display("FAIL release fx cyc %0d: got %b want %b", i, obs_fx, e.fx); else passed++;
            if (i < 3) begin
                if (g_rr !== 3'b001) $display("FAIL release_hold: got %b want 001", g_rr); else passed++;
            end else begin
                if ({g_rr, v_rr, m_rr} !== {3'b000, 1'b0, 2'd0})
                    $display("FAIL release_idle: got %b/%b/%0d want 000/0/0", g_rr, v_rr, m_rr);
                else passed++;
            end
        end
    endtask

    task automatic test_lock();
        exp_t e;
        logic [2:0] req, lock, want;
        for (int i = 0; i < 18; i++) begin
            if (i == 0)       begin req = 3'b100; lock = 3'b000; want = 3'b100; end
            else if (i <= 10) begin req = 3'b111; lock = 3'b100; want = 3'b100; end
            else if (i == 11) begin req = 3'b011; lock = 3'b000; want = 3'b001; end
            else              begin req = 3'b001; lock = 3'b000; want = 3'b001; end
            cycle(req, lock, 1'b1, 1'b0);
            e = sb.pop_front();
            checks += 3;
            if (obs_rr !== e.rr) $display("FAIL lock rr cyc %0d: got %b want %b", i, obs_rr, e.rr); else passed++;
            if (obs_fx !== e.fx) $display("FAIL lock fx cyc %0d: got %b want %b", i, obs_fx, e.fx); else passed++;
            if (g_rr !== want) $display("FAIL lock_grant cyc %0d: got %b want %b", i, g_rr, want); else passed++;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic       rdy, rst;
        for (int i = 0; i < 4; i++) begin
            rdy = (i == 0);
            rst = (i == 2);
            cycle(3'b010, 3'b000, rdy, rst);
            e = sb.pop_front();
            checks += 2;
            if (obs_rr !== e.rr) $display("FAIL reset_mid rr cyc %0d: got %b want %b", i, obs_rr, e.rr); else passed++;
            if (obs_fx !== e.fx) $display("FAIL reset_mid fx cyc %0d: got %b want %b", i, obs_fx, e.fx); else passed++;
            if (i == 2) begin
                checks++;
                if ({obs_rr, obs_fx} !== 18'b0)
                    $display("FAIL reset_mid_zero: got %b %b want all 0", obs_rr, obs_fx);
                else passed++;
            end
            if (i == 3) begin
                checks++;
                if ({g_rr, g_fx} !== {3'b010, 3'b010})
                    $display("FAIL reset_mid_regrant: got %b %b want 010 010", g_rr, g_fx);
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        exp_t e;
        logic [2:0] req, lock;
        logic       rdy, rst;
        for (int i = 0; i < 400; i++) begin
            req  = 3'($urandom);
            lock = 3'($urandom) & 3'($urandom);
            rdy  = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 60) == 0);
            cycle(req, lock, rdy, rst);
            e = sb.pop_front();
            checks += 2;
            if (obs_rr !== e.rr) $display("FAIL random rr cyc %0d: got %b want %b", i, obs_rr, e.rr); else passed++;
            if (obs_fx !== e.fx) $display("FAIL random fx cyc %0d: got %b want %b", i, obs_fx, e.fx); else passed++;
        end
    endtask

    initial begin
        hreq = 3'b000; hmastlock = 3'b000; hready = 1'b1; hreset = 1'b1;
        ms_rr = mreset();
        ms_fx = mreset();
        test_reset();
        test_first_grant();
        test_quantum();
        test_release_wait();
        test_lock();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
